// File: rtl/fifo8_to_256.sv
// Byte-to-word packing FIFO: 32 bytes are packed into one 256-bit word, and the words are queued in a DEPTH-entry word FIFO.
// Define FIFO8_TO_256_FLUSH_EN to add the flush input, which pushes a zero-padded partial word.
module fifo8_to_256 #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          sclk,
  input  logic          srst,
  input  logic          wren,
  input  logic [7:0]    data8,
  output logic          full,
`ifdef FIFO8_TO_256_FLUSH_EN
  input  logic          flush,
`endif
  input  logic          rden,
  output logic [255:0]  data256,
  output logic          empty,
  output logic [AW:0]   words,
  output logic [4:0]    byte_cnt,
  output logic          ovf
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [247:0]  r_partial;
  logic [4:0]    r_byte_cnt;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_words;
  logic          r_ovf;
  logic [255:0]  r_data256;
  logic [255:0]  r_mem [DEPTH];

  logic          w_full;
  logic          w_empty;
  logic          w_accept;
  logic          w_pop;
  logic          w_word_done;
  logic          w_push;
  logic [255:0]  w_push_word;

  assign w_full      = (r_words == DEPTH_W);
  assign w_empty     = (r_words == '0);
  assign w_accept    = wren & ~w_full;
  assign w_pop       = rden & ~w_empty;
  assign w_word_done = w_accept & (r_byte_cnt == 5'd31);

`ifdef FIFO8_TO_256_FLUSH_EN
  logic [5:0]   w_fill;
  logic [4:0]   w_pad;
  logic [255:0] w_assembled;
  logic         w_flush_push;

  // The partial register is right-aligned, so shift the flushed bytes up to the top lanes.
  assign w_fill       = {1'b0, r_byte_cnt} + {5'd0, w_accept};
  assign w_pad        = 5'(6'd32 - w_fill);
  assign w_assembled  = w_accept ? {r_partial, data8} : {8'h00, r_partial};
  assign w_flush_push = flush & ~w_full & (w_fill != 6'd0);
  assign w_push       = w_word_done | w_flush_push;
  assign w_push_word  = w_assembled << {w_pad, 3'b000};
`else
  assign w_push       = w_word_done;
  assign w_push_word  = {r_partial, data8};
`endif

  always_ff @(posedge sclk) begin
    if (srst) begin
      r_partial  <= '0;
      r_byte_cnt <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_words    <= '0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_push) begin
        r_partial  <= '0;
        r_byte_cnt <= '0;
        r_wptr     <= r_wptr + AW'(1);
      end else if (w_accept) begin
        r_partial  <= {r_partial[239:0], data8};
        r_byte_cnt <= r_byte_cnt + 5'd1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      // A push and a pop on the same edge leave the count unchanged.
      case ({w_push, w_pop})
        2'b10:   r_words <= r_words + (AW+1)'(1);
        2'b01:   r_words <= r_words - (AW+1)'(1);
        default: r_words <= r_words;
      endcase
      if (wren & w_full) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // The word storage has no reset, so it can be mapped to block RAM.
  always_ff @(posedge sclk) begin
    if (w_push & ~srst) begin
      r_mem[r_wptr] <= w_push_word;
    end
  end

  always_ff @(posedge sclk) begin
    if (srst) begin
      r_data256 <= '0;
    end else if (w_pop) begin
      r_data256 <= r_mem[r_rptr];
    end
  end

  assign full     = w_full;
  assign empty    = w_empty;
  assign words    = r_words;
  assign byte_cnt = r_byte_cnt;
  assign ovf      = r_ovf;
  assign data256  = r_data256;

endmodule

// File: tb/tb_fifo8_to_256.sv
// Scoreboard bench for fifo8_to_256: the expected words are queued as bytes are driven, and compared when they are popped.
`timescale 1ns/1ps
module tb_fifo8_to_256;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic         sclk = 1'b0;
  logic         srst;
  logic         wren;
  logic [7:0]   data8;
  logic         rden;
`ifdef FIFO8_TO_256_FLUSH_EN
  logic         flush;
`endif
  logic         full;
  logic         empty;
  logic [255:0] data256;
  logic [AW:0]  words;
  logic [4:0]   byte_cnt;
  logic         ovf;

  always #5 sclk = ~sclk;

  fifo8_to_256 #(.DEPTH(DEPTH), .AW(AW)) dut (
    .sclk     (sclk),
    .srst     (srst),
    .wren     (wren),
    .data8    (data8),
    .full     (full),
`ifdef FIFO8_TO_256_FLUSH_EN
    .flush    (flush),
`endif
    .rden     (rden),
    .data256  (data256),
    .empty    (empty),
    .words    (words),
    .byte_cnt (byte_cnt),
    .ovf      (ovf)
  );

  logic [255:0] exp_q[$];
  logic [7:0]   m_bytes[$];
  int           m_words;
  logic [255:0] m_data;
  int           total = 0;
  int           bad   = 0;
  int           pops  = 0;

  task automatic do_reset();
    srst = 1'b1;
    wren = 1'b0;
    rden = 1'b0;
`ifdef FIFO8_TO_256_FLUSH_EN
    flush = 1'b0;
`endif
    @(posedge sclk); #1;
    srst = 1'b0;
    exp_q.delete();
    m_bytes.delete();
    m_words = 0;
    m_data  = '0;
  endtask

  // Drive one cycle, update the reference model and compare any popped word.
  task automatic step(input bit wr, input logic [7:0] d, input bit rd, input bit fl);
    bit acc, pop, pushw;
    logic [255:0] w;
    wren  = wr;
    data8 = d;
    rden  = rd;
`ifdef FIFO8_TO_256_FLUSH_EN
    flush = fl;
`endif
    acc = wr && (m_words < DEPTH);
    pop = rd && (m_words > 0);
    if (acc) m_bytes.push_back(d);
    pushw = (m_bytes.size() == 32);
`ifdef FIFO8_TO_256_FLUSH_EN
    if (fl && (m_words < DEPTH) && (m_bytes.size() > 0)) pushw = 1'b1;
`else
    if (fl) pushw = pushw;
`endif
    if (pushw) begin
      w = '0;
      for (int i = 0; i < m_bytes.size(); i++) w[255-8*i -: 8] = m_bytes[i];
      exp_q.push_back(w);
      m_bytes.delete();
      m_words++;
    end
    if (pop) begin
      m_data = exp_q.pop_front();
      m_words--;
    end
    @(posedge sclk); #1;
    wren = 1'b0;
    rden = 1'b0;
`ifdef FIFO8_TO_256_FLUSH_EN
    flush = 1'b0;
`endif
    if (pop) begin
      total++;
      if (data256 !== m_data) begin
        bad++;
        $display("FAIL pop_data #%0d: got %h want %h", pops, data256, m_data);
      end else begin
        $display("pop word %0d: %h", pops, data256);
      end
      pops++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (words !== '0 || byte_cnt !== 5'd0 || empty !== 1'b1 || full !== 1'b0 ||
        ovf !== 1'b0 || data256 !== '0) begin
      bad++;
      $display("FAIL reset_state: words=%0d cnt=%0d empty=%b full=%b ovf=%b data=%h want 0,0,1,0,0,0",
               words, byte_cnt, empty, full, ovf, data256);
    end
    for (int i = 0; i < 10; i++) step(1'b1, 8'(i + 1), 1'b0, 1'b0);
    total++;
    if (byte_cnt !== 5'd10) begin
      bad++; $display("FAIL cnt_10: got %0d want 10", byte_cnt);
    end
    do_reset();
    total++;
    if (byte_cnt !== 5'd0 || words !== '0 || empty !== 1'b1 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: cnt=%0d words=%0d empty=%b ovf=%b want 0,0,1,0", byte_cnt, words, empty, ovf);
    end
  endtask

  task automatic test_single_word();
    logic [255:0] lit;
    lit = 256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F;
    do_reset();
    for (int i = 0; i < 31; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    total++;
    if (empty !== 1'b1 || byte_cnt !== 5'd31) begin
      bad++; $display("FAIL before_32nd: empty=%b cnt=%0d want 1,31", empty, byte_cnt);
    end
    step(1'b1, 8'h1F, 1'b0, 1'b0);
    total++;
    if (empty !== 1'b0 || words !== 3'd1 || byte_cnt !== 5'd0) begin
      bad++; $display("FAIL after_32nd: empty=%b words=%0d cnt=%0d want 0,1,0", empty, words, byte_cnt);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    total++;
    if (data256 !== lit) begin
      bad++; $display("FAIL word_0_1f: got %h want %h", data256, lit);
    end
    total++;
    if (empty !== 1'b1) begin
      bad++; $display("FAIL empty_after_read: got %b want 1", empty);
    end
  endtask

  task automatic test_full_ovf();
    do_reset();
    for (int i = 0; i < DEPTH*32; i++) step(1'b1, 8'(i*7 + 3), 1'b0, 1'b0);
    total++;
    if (full !== 1'b1 || words !== 3'(DEPTH) || ovf !== 1'b0) begin
      bad++; $display("FAIL fill: full=%b words=%0d ovf=%b want 1,%0d,0", full, words, ovf, DEPTH);
    end
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    total++;
    if (ovf !== 1'b1 || byte_cnt !== 5'd0) begin
      bad++; $display("FAIL drop_aa: ovf=%b cnt=%0d want 1,0", ovf, byte_cnt);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    total++;
    if (full !== 1'b0 || words !== 3'(DEPTH-1)) begin
      bad++; $display("FAIL after_pop: full=%b words=%0d want 0,%0d", full, words, DEPTH-1);
    end
    for (int i = 0; i < 32; i++) step(1'b1, 8'(200 + i), 1'b0, 1'b0);
    total++;
    if (full !== 1'b1) begin
      bad++; $display("FAIL refill: full=%b want 1", full);
    end
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    total++;
    if (empty !== 1'b1 || data256 !== m_data || ovf !== 1'b1) begin
      bad++; $display("FAIL read_empty: empty=%b ovf=%b data=%h want 1,1,%h", empty, ovf, data256, m_data);
    end
  endtask

  task automatic test_back_to_back();
    int over, start;
    over  = 0;
    do_reset();
    start = pops;
    for (int i = 0; i < 8*32; i++) begin
      step(1'b1, 8'(i*13 + 5), (m_words > 0), 1'b0);
      if (words > 3'd1 || words !== 3'(m_words)) over++;
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    total++;
    if (over != 0 || pops - start != 8 || empty !== 1'b1) begin
      bad++; $display("FAIL stream_wrap: word_errs=%0d popped=%0d empty=%b want 0,8,1", over, pops - start, empty);
    end
  endtask

  task automatic test_push_pop_same_edge();
    do_reset();
    for (int i = 0; i < 32; i++) step(1'b1, 8'(64 + i), 1'b0, 1'b0);
    for (int i = 0; i < 31; i++) step(1'b1, 8'(128 + i), 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b1, 1'b0);
    total++;
    if (words !== 3'd1 || data256[255:248] !== 8'h40 || data256[7:0] !== 8'h5F) begin
      bad++; $display("FAIL push_pop: words=%0d top=%h bot=%h want 1,40,5f", words, data256[255:248], data256[7:0]);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_flush();
    do_reset();
    step(1'b1, 8'hA1, 1'b0, 1'b0);
    step(1'b1, 8'hA2, 1'b0, 1'b0);
    step(1'b1, 8'hA3, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
`ifdef FIFO8_TO_256_FLUSH_EN
    total++;
    if (words !== 3'd1 || byte_cnt !== 5'd0) begin
      bad++; $display("FAIL flush_push: words=%0d cnt=%0d want 1,0", words, byte_cnt);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    total++;
    if (data256 !== (256'hA1A2A3 << 232)) begin
      bad++; $display("FAIL flush_word: got %h want a1a2a3 zero-padded", data256);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    total++;
    if (words !== 3'd0 || byte_cnt !== 5'd0) begin
      bad++; $display("FAIL flush_idle: words=%0d cnt=%0d want 0,0", words, byte_cnt);
    end
    step(1'b1, 8'hB4, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
`else
    total++;
    if (empty !== 1'b1 || byte_cnt !== 5'd3) begin
      bad++; $display("FAIL no_flush: empty=%b cnt=%0d want 1,3", empty, byte_cnt);
    end
`endif
  endtask

  initial begin
    srst  = 1'b1;
    wren  = 1'b0;
    rden  = 1'b0;
    data8 = 8'h00;
    test_reset();
    test_single_word();
    test_full_ovf();
    test_back_to_back();
    test_push_pop_same_edge();
    test_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
